// File: rtl/rom_read_arbiter.sv
// Round-robin arbiter giving two clients shared read access to a dual-port ROM
// with registered outputs; one read is in flight at a time, four cycles per read.
module rom_read_arbiter #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_a,
  input  logic [ADDR_W-1:0] addr_in_a,
  output logic              gnt_a,
  output logic [DATA_W-1:0] rdata_a,
  output logic              rvalid_a,
  input  logic              req_b,
  input  logic [ADDR_W-1:0] addr_in_b,
  output logic              gnt_b,
  output logic [DATA_W-1:0] rdata_b,
  output logic              rvalid_b,
  output logic              busy,
  output logic              ena,
  output logic              enb,
  output logic [ADDR_W-1:0] addra,
  output logic [ADDR_W-1:0] addrb,
  input  logic [DATA_W-1:0] data_outa,
  input  logic [DATA_W-1:0] data_outb,
  output logic [1:0]        dbg_state
);

  // Handshake: a client holds req high until its one-cycle gnt; req is only
  // looked at in IDLE, and rvalid pulses once, two cycles after gnt.
  typedef enum logic [1:0] {IDLE, ISSUE, CAPT, RESP} state_t;

  state_t state_q, state_d;
  logic   sel_q, sel_d;   // client being served: 0 = A, 1 = B
  logic   ptr_q, ptr_d;   // client favoured on a tie: 0 = A, 1 = B

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= 1'b0;
      ptr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (req_a || req_b) begin
          sel_d   = (req_a && req_b) ? ptr_q : req_b;
          ptr_d   = ~sel_d;
          state_d = ISSUE;
        end
      end
      ISSUE:   state_d = CAPT;
      CAPT:    state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Address captured once, on the acceptance edge; ROM data captured in CAPT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addra   <= '0;
      addrb   <= '0;
      rdata_a <= '0;
      rdata_b <= '0;
    end else begin
      if (state_q == IDLE && state_d == ISSUE) begin
        if (sel_d) addrb <= addr_in_b;
        else       addra <= addr_in_a;
      end
      if (state_q == CAPT) begin
        if (sel_q) rdata_b <= data_outb;
        else       rdata_a <= data_outa;
      end
    end
  end

  always_comb begin
    gnt_a     = (state_q == ISSUE) && !sel_q;
    gnt_b     = (state_q == ISSUE) &&  sel_q;
    ena       = gnt_a;
    enb       = gnt_b;
    rvalid_a  = (state_q == RESP) && !sel_q;
    rvalid_b  = (state_q == RESP) &&  sel_q;
    busy      = (state_q != IDLE);
    dbg_state = state_q;
  end

endmodule

// File: tb/tb_rom_read_arbiter.sv
// Directed bench for rom_read_arbiter against an 8x4 registered dual-port ROM
// model; responses are checked by a monitor popping an expected queue.
module tb_rom_read_arbiter;

  localparam int ADDR_W = 3;
  localparam int DATA_W = 4;

  logic              clk, rst_n;
  logic              req_a, req_b, gnt_a, gnt_b, rvalid_a, rvalid_b, busy;
  logic [ADDR_W-1:0] addr_in_a, addr_in_b, addra, addrb;
  logic [DATA_W-1:0] rdata_a, rdata_b, data_outa, data_outb;
  logic              ena, enb;
  logic [1:0]        dbg_state;

  logic [DATA_W-1:0] rom [8];
  logic [DATA_W:0]   exp_q[$];   // {client, data}
  int                total = 0;
  int                bad   = 0;

  rom_read_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_a(req_a), .addr_in_a(addr_in_a), .gnt_a(gnt_a), .rdata_a(rdata_a), .rvalid_a(rvalid_a),
    .req_b(req_b), .addr_in_b(addr_in_b), .gnt_b(gnt_b), .rdata_b(rdata_b), .rvalid_b(rvalid_b),
    .busy(busy), .ena(ena), .enb(enb), .addra(addra), .addrb(addrb),
    .data_outa(data_outa), .data_outb(data_outb), .dbg_state(dbg_state)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ROM model: registered outputs, valid one cycle after the enable
  initial begin
    rom[0] = 4'h1; rom[1] = 4'h3; rom[2] = 4'hA; rom[3] = 4'h6;
    rom[4] = 4'h7; rom[5] = 4'hD; rom[6] = 4'h9; rom[7] = 4'hB;
  end
  always @(posedge clk) begin
    if (ena) data_outa <= rom[addra];
    if (enb) data_outb <= rom[addrb];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (rst_n) begin
      logic [DATA_W:0] e;
      if (ena || enb) chk("ena/enb exclusive", {31'd0, ena && enb}, 0);
      if (rvalid_a) begin
        chk("rvalid_a pending", {31'd0, exp_q.size() > 0}, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("rvalid_a data", {1'b0, rdata_a}, e);
        end
      end
      if (rvalid_b) begin
        chk("rvalid_b pending", {31'd0, exp_q.size() > 0}, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("rvalid_b data", {1'b1, rdata_b}, e);
        end
      end
    end
  end

  // Driver tasks
  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("reset outputs", {gnt_a, gnt_b, rvalid_a, rvalid_b, busy, ena, enb}, 0);
    chk("reset addr", {addra, addrb}, 0);
    chk("reset rdata", {rdata_a, rdata_b}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One read by client cl; addr_in switches to late_addr once granted
  task automatic do_read(input bit cl, input logic [ADDR_W-1:0] addr,
                         input logic [ADDR_W-1:0] late_addr, input logic [DATA_W-1:0] exp_data);
    int gk = 0;
    int rk = 0;
    @(negedge clk);
    if (cl) begin req_b = 1'b1; addr_in_b = addr; end
    else    begin req_a = 1'b1; addr_in_a = addr; end
    exp_q.push_back({cl, exp_data});
    for (int k = 1; k <= 12 && rk == 0; k++) begin
      @(negedge clk);
      if ((cl ? gnt_b : gnt_a) && gk == 0) begin
        gk = k;
        chk("enable with gnt", {31'd0, cl ? enb : ena}, 1);
        chk("latched addr", {29'd0, cl ? addrb : addra}, {29'd0, addr});
        if (cl) begin req_b = 1'b0; addr_in_b = late_addr; end
        else    begin req_a = 1'b0; addr_in_a = late_addr; end
      end
      if (cl ? rvalid_b : rvalid_a) rk = k;
      if (k <= 3) chk("busy in read", {31'd0, busy}, 1);
    end
    chk("gnt latency", gk, 1);
    chk("rvalid latency", rk, 3);
    @(negedge clk);
    chk("idle after read", {busy, gnt_a, gnt_b, rvalid_a, rvalid_b}, 0);
  endtask

  initial begin
    int ga, gb, ra, rb, n;
    rst_n = 1'b1; req_a = 1'b0; req_b = 1'b0; addr_in_a = '0; addr_in_b = '0;
    apply_reset();

    // Single read: addr 2 -> 0xA
    do_read(1'b0, 3'd2, 3'd2, 4'hA);
    chk("single rdata_a", {28'd0, rdata_a}, 32'hA);
    chk("single rdata_b untouched", {28'd0, rdata_b}, 0);

    // Simultaneous after reset: A (addr 5) first, then B (addr 7)
    apply_reset();
    @(negedge clk);
    req_a = 1'b1; addr_in_a = 3'd5; req_b = 1'b1; addr_in_b = 3'd7;
    exp_q.push_back({1'b0, 4'hD});
    exp_q.push_back({1'b1, 4'hB});
    ga = 0; gb = 0; ra = 0; rb = 0;
    for (int k = 1; k <= 20 && rb == 0; k++) begin
      @(negedge clk);
      if (gnt_a) begin ga = k; req_a = 1'b0; end
      if (gnt_b) begin gb = k; req_b = 1'b0; end
      if (rvalid_a) ra = k;
      if (rvalid_b) rb = k;
    end
    chk("simul gnt_a cycle", ga, 1);
    chk("simul gnt_b cycle", gb, 5);
    chk("simul rvalid_a cycle", ra, 3);
    chk("simul rvalid spacing", rb - ra, 4);
    chk("simul rdata_a held", {28'd0, rdata_a}, 32'hD);

    // Fairness: both held for six reads, expect A,B,A,B,A,B
    @(negedge clk);
    req_a = 1'b1; addr_in_a = 3'd1; req_b = 1'b1; addr_in_b = 3'd6;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back({1'b0, 4'h3});
      exp_q.push_back({1'b1, 4'h9});
    end
    n = 0;
    for (int k = 0; k < 60 && (n < 6 || exp_q.size() > 0); k++) begin
      @(negedge clk);
      if (gnt_a || gnt_b) begin
        chk($sformatf("fair grant %0d", n), {31'd0, gnt_b}, n % 2);
        n++;
        if (n == 6) begin req_a = 1'b0; req_b = 1'b0; end
      end
    end
    chk("fair grant count", n, 6);
    chk("fair queue drained", exp_q.size(), 0);

    // Address change after sampling: addr 0 sampled, 3 presented later
    do_read(1'b1, 3'd0, 3'd3, 4'h1);
    chk("addr change rdata_b", {28'd0, rdata_b}, 32'h1);
    chk("addr change rdata_a kept", {28'd0, rdata_a}, 32'h3);

    // Reset in CAPT aborts the read
    @(negedge clk);
    req_a = 1'b1; addr_in_a = 3'd2;
    @(negedge clk);
    chk("abort gnt_a", {31'd0, gnt_a}, 1);
    req_a = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort outputs", {gnt_a, gnt_b, rvalid_a, rvalid_b, busy, ena, enb}, 0);
    chk("abort addr", {addra, addrb}, 0);
    chk("abort rdata", {rdata_a, rdata_b}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("quiet after abort", {gnt_a, gnt_b, rvalid_a, rvalid_b, busy}, 0);
    end
    do_read(1'b1, 3'd4, 3'd4, 4'h7);
    chk("post-reset rdata_b", {28'd0, rdata_b}, 32'h7);
    chk("post-reset rdata_a", {28'd0, rdata_a}, 0);

    chk("final queue empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
